// File: rtl/rob_pkg.sv
// Shared ROB types and sizing for the completion tracker.
// Imported by every ROB-side block.
package rob_pkg;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_ID_W  = 5;

  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef logic [ROB_ID_W:0]   rob_cnt_t;

  function automatic rob_cnt_t rob_popcnt2(input logic [1:0] v);
    return rob_cnt_t'(v[0]) + rob_cnt_t'(v[1]);
  endfunction
endpackage

// File: rtl/rob_completion_tracker.sv
// In-order completion tracker for the 32-entry ROB.
// Two alloc slots, two writeback ports, two commit slots.
module rob_completion_tracker
  import rob_pkg::*;
(
  input  logic            cpu_clock_i,
  input  logic            cpu_rst_n_i,
  input  logic            flush_i,
  input  logic [1:0]      alloc_req_i,
  output logic            alloc_ready_o,
  output logic [4:0]      alloc_id0_o,
  output logic [4:0]      alloc_id1_o,
  input  logic            cmp0_valid_i,
  input  logic [4:0]      cmp0_rob_id_i,
  input  logic            cmp1_valid_i,
  input  logic [4:0]      cmp1_rob_id_i,
  output logic [1:0]      commit_valid_o,
  output logic [4:0]      commit_id0_o,
  output logic [4:0]      commit_id1_o,
  input  logic            commit_ready_i,
  output logic [5:0]      occupancy_o
);

  rob_id_t              head_q, head_d;
  rob_id_t              tail_q, tail_d;
  rob_cnt_t             count_q, count_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;

  rob_id_t  head_p1, tail_p1;
  rob_id_t  off0, off1;
  rob_cnt_t n_alloc, n_commit;
  logic     alloc_ready, alloc_fire;
  logic     valid0, valid1;
  logic     live0, live1;

  assign head_p1 = head_q + rob_id_t'(1);
  assign tail_p1 = tail_q + rob_id_t'(1);

  assign alloc_ready = count_q <= rob_cnt_t'(ROB_DEPTH - 2);
  assign alloc_fire  = alloc_ready && (alloc_req_i != 2'b00) && !flush_i;
  assign n_alloc     = alloc_fire ? rob_popcnt2(alloc_req_i) : '0;

  assign valid0 = (count_q >= rob_cnt_t'(1)) && done_q[head_q];
  assign valid1 = valid0 && (count_q >= rob_cnt_t'(2)) && done_q[head_p1];

  assign n_commit = (commit_ready_i && !flush_i)
                  ? rob_popcnt2({valid1, valid0}) : '0;

  // An ID is live when its distance from head is below the count.
  assign off0  = cmp0_rob_id_i - head_q;
  assign off1  = cmp1_rob_id_i - head_q;
  assign live0 = {1'b0, off0} < count_q;
  assign live1 = {1'b0, off1} < count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else begin
      if (cmp0_valid_i && live0) done_d[cmp0_rob_id_i] = 1'b1;
      if (cmp1_valid_i && live1) done_d[cmp1_rob_id_i] = 1'b1;
      if (alloc_fire) begin
        done_d[tail_q] = 1'b0;
        if (n_alloc == rob_cnt_t'(2)) done_d[tail_p1] = 1'b0;
      end
      tail_d  = tail_q + n_alloc[ROB_ID_W-1:0];
      head_d  = head_q + n_commit[ROB_ID_W-1:0];
      count_d = count_q + n_alloc - n_commit;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (!cpu_rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign alloc_ready_o  = alloc_ready;
  assign alloc_id0_o    = tail_q;
  assign alloc_id1_o    = tail_p1;
  assign commit_valid_o = {valid1, valid0};
  assign commit_id0_o   = head_q;
  assign commit_id1_o   = head_p1;
  assign occupancy_o    = count_q;

endmodule

// File: doc/rob_completion_tracker.md
Name: rob_completion_tracker

Overview:
- In-order completion tracker for the 32-entry reorder buffer.
- Rename allocates up to two ROB IDs per cycle.
- Two writeback ports mark entries done:
  - port 0 is driven directly by the EX-stage writeback merge (rob_id/rob_valid);
  - port 1 is driven by the load/store/branch unit.
- Presents up to two oldest completed entries per cycle to commit, strictly in program order.

Parameters:
- DEPTH, 32, number of ROB entries; power of two; ID width = log2(DEPTH) = 5.
- CMP_PORTS, 2, completion ports; fixed at 2 in this revision.

Ports:
- cpu_clock_i  in  1  core clock; all state updates on rising edge.
- cpu_rst_n_i  in  1  synchronous reset, active-low.
- flush_i  in  1  pipeline flush; empties tracker.
- alloc_req_i  in  2  allocation request per slot; legal values 00, 01, 11 only.
- alloc_ready_o  out  1  at least two free entries (count <= DEPTH-2).
- alloc_id0_o  out  5  ID given to slot 0 (= tail).
- alloc_id1_o  out  5  ID given to slot 1 (= tail+1 mod 32).
- cmp0_valid_i  in  1  completion port 0 valid (from EX writeback merge).
- cmp0_rob_id_i  in  5  completing ID, port 0.
- cmp1_valid_i  in  1  completion port 1 valid (memory/branch unit).
- cmp1_rob_id_i  in  5  completing ID, port 1.
- commit_valid_o  out  2  bit0: head committable; bit1: head+1 also committable.
- commit_id0_o  out  5  head ID.
- commit_id1_o  out  5  head+1 ID.
- commit_ready_i  in  1  commit stage accepts all slots shown in commit_valid_o this cycle.
- occupancy_o  out  6  live entry count, 0..32.

Behaviour:
- State:
  - head[4:0], tail[4:0], count[5:0];
  - done[31:0], one bit per entry.
- Reset (cpu_rst_n_i=0 at edge): head=tail=0, count=0, done=0. Outputs after reset:
  - alloc_ready_o=1;
  - alloc_id0_o=0, alloc_id1_o=1;
  - commit_valid_o=00;
  - commit_id0_o=0, commit_id1_o=1;
  - occupancy_o=0.
- Allocation:
  - Fires when alloc_ready_o && alloc_req_i!=00 && !flush_i.
  - n = popcount(alloc_req_i).
  - Clears done[tail] (and done[tail+1] when n=2).
  - tail += n, modulo 32.
  - A request while alloc_ready_o=0 is ignored; rename must stall.
  - alloc_ready_o uses current-cycle count only; same-cycle commits are not credited.
- Completion:
  - Each valid port sets done[id] at the edge, visible to commit logic the next cycle.
  - There is no same-cycle bypass.
  - Both ports naming the same ID is legal (idempotent).
  - Completion to an unallocated ID is a protocol error; the RTL ignores it, and the bench asserts it never happens.
  - All completions are ignored in a flush cycle.
- Commit (combinational from registered state):
  - valid0 = count>=1 && done[head].
  - valid1 = valid0 && count>=2 && done[head+1].
  - When commit_ready_i=1, k = valid0+valid1 entries retire: head += k, count -= k.
  - Retiring entries' done bits are left as-is and cleared on re-allocation.
- Count update:
  - count_next = count + n_alloc - k_commit, all in one cycle.
  - Alloc and commit in the same cycle are legal, including at count=32 (alloc blocked) and count=0 (commit blocked).
- Wrap-around:
  - head and tail wrap 31->0 naturally (5-bit).
  - full vs empty is resolved by count, never by pointer compare.
- Flush:
  - Next cycle: head=tail=0, count=0, done=0.
  - Takes priority over allocation, completion and commit in the same cycle; commit_valid_o remains combinational during the flush cycle, but no retirement is recorded.
- Reset asserted mid-operation behaves identically to flush plus restoring reset output values.
- No combinational path from alloc_req_i or cmp*_i to any output.

Decomposition:
- Shared package (rob_pkg), containing:
  - ROB_DEPTH=32, ROB_ID_W=5;
  - typedef rob_id_t (logic [4:0]);
  - typedef rob_cnt_t (logic [5:0]).
- No sub-module required.
- Optional small helper rob_commit_sel computes valid0/valid1 from done/head/count; keep it inline unless reused by the exception unit.

Test Plan:
- Reset then alloc_req_i=11 at cycle 1 -> alloc_id0_o=0, alloc_id1_o=1; next cycle occupancy_o=2, alloc_id0_o=2, commit_valid_o=00.
- Allocate IDs 0,1; complete ID1 on cmp0 -> commit_valid_o stays 00. Then complete ID0 on cmp1 -> next cycle commit_valid_o=11, ids 0/1. With commit_ready_i=1: occupancy_o goes 2->0, head=2.
- Fill to 32 with pairs -> alloc_ready_o=0 when count=31 or 32. Request 11 at count=32 -> ignored, tail unchanged. Commit 2 -> alloc_ready_o=1 next cycle.
- Run 40 alloc/complete/commit pairs so tail wraps 31->0 -> commit IDs follow sequence ...30,31,0,1. occupancy_o never exceeds 32.
- Same cycle: alloc 11 at count=10 and commit 2 with ready=1 -> occupancy_o=10 next cycle. cmp0 and cmp1 both on ID 5 -> done[5]=1, no error.
- flush_i with count=17 and concurrent alloc/completion -> next cycle occupancy_o=0, alloc_id0_o=0, commit_valid_o=00; a completion to ID 3 in the flush cycle leaves done[3]=0.
